// File: rtl/lsu_mem_arbiter_pkg.sv
// lsu_pkg: shared types and constants for the LSU data-memory arbiter
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {REQ_LD, REQ_ST} req_id_t;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/lsu_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-input round-robin pick; bit 0 = load, bit 1 = store
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       rr_ptr,
  output logic [1:0] grant,
  output logic       grant_valid
);
  assign grant[0] = eligible[0] & (~eligible[1] | ~rr_ptr);
  assign grant[1] = eligible[1] & (~eligible[0] | rr_ptr);
  assign grant_valid = |eligible;
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the data-memory port between load and store units
module lsu_mem_arbiter
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_gnt,
  output logic        ld_rsp_valid,
  output logic [31:0] ld_rsp_data,
  output logic        ld_stall,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_wstrb,
  output logic        st_gnt,
  output logic        st_done,
  output logic        st_stall,
  output logic        mem_en,
  output logic        mem_rw_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);
  arb_state_t state;
  req_id_t owner;
  req_id_t rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic grant_valid;
  logic arb_en;
  logic owned;

  assign owned = state != IDLE;
  assign eligible = {st_req & ~(owned & (owner == REQ_ST)), ld_req & ~(owned & (owner == REQ_LD))};
  assign arb_en = ~i_rst & (state != BUSY);

  rr_arb2 u_rr_arb2 (
    .eligible(eligible),
    .rr_ptr(rr_ptr == REQ_ST),
    .grant(grant),
    .grant_valid(grant_valid)
  );

  assign ld_gnt = arb_en & grant[0];
  assign st_gnt = arb_en & grant[1];
  assign ld_stall = ld_req & ~ld_rsp_valid;
  assign st_stall = st_req & ~st_done;

  // access sequencer: grant/latch, hold the port for MEM_LATENCY cycles, then respond
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      owner <= REQ_LD;
      rr_ptr <= REQ_LD;
      cnt <= '0;
      ld_rsp_valid <= 1'b0;
      ld_rsp_data <= '0;
      st_done <= 1'b0;
      mem_en <= 1'b0;
      mem_rw_mode <= MEM_READ;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      ld_rsp_valid <= 1'b0;
      st_done <= 1'b0;
      if (state == BUSY) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          state <= RESP;
          mem_en <= 1'b0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
          ld_rsp_valid <= owner == REQ_LD;
          st_done <= owner == REQ_ST;
          if (owner == REQ_LD) ld_rsp_data <= mem_rdata;
        end
      end else if (grant_valid) begin
        state <= BUSY;
        owner <= grant[1] ? REQ_ST : REQ_LD;
        rr_ptr <= grant[1] ? REQ_LD : REQ_ST;
        cnt <= CNT_W'(MEM_LATENCY - 1);
        mem_en <= 1'b1;
        mem_rw_mode <= grant[1] ? MEM_WRITE : MEM_READ;
        mem_addr <= grant[1] ? st_addr : ld_addr;
        mem_wdata <= grant[1] ? st_wdata : '0;
        mem_wstrb <= grant[1] ? st_wstrb : '0;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed and random checks of two arbiter instances (latency 2 and 1)
module tb_lsu_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        ld_req [2];
  logic [31:0] ld_addr [2];
  logic        st_req [2];
  logic [31:0] st_addr [2];
  logic [31:0] st_wdata [2];
  logic [3:0]  st_wstrb [2];
  logic        ld_gnt [2];
  logic        ld_rsp_valid [2];
  logic [31:0] ld_rsp_data [2];
  logic        ld_stall [2];
  logic        st_gnt [2];
  logic        st_done [2];
  logic        st_stall [2];
  logic        mem_en [2];
  logic        mem_rw_mode [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic [31:0] mem_rdata [2];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata[0] = rd_fn(mem_addr[0]);
  assign mem_rdata[1] = rd_fn(mem_addr[1]);

  lsu_mem_arbiter #(.MEM_LATENCY(2)) u_lat2 (
    .i_clk(clk), .i_rst(rst[0]),
    .ld_req(ld_req[0]), .ld_addr(ld_addr[0]), .ld_gnt(ld_gnt[0]),
    .ld_rsp_valid(ld_rsp_valid[0]), .ld_rsp_data(ld_rsp_data[0]), .ld_stall(ld_stall[0]),
    .st_req(st_req[0]), .st_addr(st_addr[0]), .st_wdata(st_wdata[0]), .st_wstrb(st_wstrb[0]),
    .st_gnt(st_gnt[0]), .st_done(st_done[0]), .st_stall(st_stall[0]),
    .mem_en(mem_en[0]), .mem_rw_mode(mem_rw_mode[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_mem_arbiter #(.MEM_LATENCY(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst[1]),
    .ld_req(ld_req[1]), .ld_addr(ld_addr[1]), .ld_gnt(ld_gnt[1]),
    .ld_rsp_valid(ld_rsp_valid[1]), .ld_rsp_data(ld_rsp_data[1]), .ld_stall(ld_stall[1]),
    .st_req(st_req[1]), .st_addr(st_addr[1]), .st_wdata(st_wdata[1]), .st_wstrb(st_wstrb[1]),
    .st_gnt(st_gnt[1]), .st_done(st_done[1]), .st_stall(st_stall[1]),
    .mem_en(mem_en[1]), .mem_rw_mode(mem_rw_mode[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL lane%0d %s: got %h expected %h at %0t", k, n, a, e, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // transaction model: one access in flight, timed by cycles since its grant
  bit          m_act [2];
  bit          m_own [2];
  bit          m_rr [2];
  bit          m_prst [2];
  int          m_t [2];
  logic [31:0] m_a [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_ws [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int L = (k == 0) ? 2 : 1;
      automatic bit busy = m_act[k] && m_t[k] >= 1 && m_t[k] <= L;
      automatic bit resp = m_act[k] && m_t[k] == L + 1;
      automatic bit le = ld_req[k] && !(m_act[k] && !m_own[k]);
      automatic bit se = st_req[k] && !(m_act[k] && m_own[k]);
      automatic bit arb = !rst[k] && (!m_act[k] || resp);
      automatic bit wl = arb && le && (!se || !m_rr[k]);
      automatic bit wst = arb && se && (!le || m_rr[k]);
      chk("ld_gnt", k, ld_gnt[k], wl);
      chk("st_gnt", k, st_gnt[k], wst);
      chk("mem_en", k, mem_en[k], busy);
      chk("ld_rsp_valid", k, ld_rsp_valid[k], resp && !m_own[k]);
      chk("st_done", k, st_done[k], resp && m_own[k]);
      chk("ld_stall", k, ld_stall[k], ld_req[k] && !(resp && !m_own[k]));
      chk("st_stall", k, st_stall[k], st_req[k] && !(resp && m_own[k]));
      if (busy) begin
        chk("mem_addr", k, mem_addr[k], m_a[k]);
        chk("mem_rw_mode", k, mem_rw_mode[k], m_own[k]);
      end
      if (!busy || m_own[k]) begin
        chk("mem_wdata", k, mem_wdata[k], busy ? m_wd[k] : 32'h0);
        chk("mem_wstrb", k, mem_wstrb[k], busy ? m_ws[k] : 4'h0);
      end
      if (resp && !m_own[k]) chk("ld_rsp_data", k, ld_rsp_data[k], rd_fn(m_a[k]));
      if (m_prst[k]) begin
        chk("post-reset mem_addr", k, mem_addr[k], 32'h0);
        chk("post-reset mem_rw_mode", k, mem_rw_mode[k], 0);
        chk("post-reset ld_rsp_data", k, ld_rsp_data[k], 32'h0);
      end
      if (rst[k]) begin
        m_act[k] <= 1'b0;
        m_rr[k] <= 1'b0;
        m_prst[k] <= 1'b1;
      end else begin
        m_prst[k] <= 1'b0;
        if (wl || wst) begin
          m_act[k] <= 1'b1;
          m_t[k] <= 1;
          m_own[k] <= wst;
          m_rr[k] <= !wst;
          m_a[k] <= wst ? st_addr[k] : ld_addr[k];
          m_wd[k] <= st_wdata[k];
          m_ws[k] <= st_wstrb[k];
        end else if (m_act[k]) begin
          if (m_t[k] == L + 1) m_act[k] <= 1'b0;
          else m_t[k] <= m_t[k] + 1;
        end
      end
    end
  end

  task automatic drain(input int k);
    automatic bit done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      automatic bit sl, ss;
      @(negedge clk);
      sl = ld_rsp_valid[k];
      ss = st_done[k];
      tick;
      if (sl) ld_req[k] = 1'b0;
      if (ss) st_req[k] = 1'b0;
      done = !ld_req[k] && !st_req[k];
    end
    chk("drain completes", k, done, 1);
    tick;
  endtask

  task automatic rand_run(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      automatic bit sl, ss;
      @(negedge clk);
      sl = ld_rsp_valid[k];
      ss = st_done[k];
      tick;
      rst[k] = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        rst[k] = 1'b1;
        ld_req[k] = 1'b0;
        st_req[k] = 1'b0;
      end else begin
        if (!ld_req[k] || sl) begin
          ld_req[k] = $urandom_range(0, 2) == 0 || (ld_req[k] && $urandom_range(0, 1) == 1);
          ld_addr[k] = $urandom;
        end
        if (!st_req[k] || ss) begin
          st_req[k] = $urandom_range(0, 2) == 0 || (st_req[k] && $urandom_range(0, 1) == 1);
          st_addr[k] = $urandom;
          st_wdata[k] = $urandom;
          st_wstrb[k] = 4'($urandom_range(0, 15));
        end
      end
    end
    rst[k] = 1'b0;
  endtask

  initial begin
    int last, ne, gl, gs;
    bit exp_st;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      ld_req[k] = 1'b0;
      st_req[k] = 1'b0;
      ld_addr[k] = '0;
      st_addr[k] = '0;
      st_wdata[k] = '0;
      st_wstrb[k] = '0;
    end
    tick;
    tick;
    rst[0] = 1'b0;
    ld_req[0] = 1'b1;
    ld_addr[0] = 32'h100;
    @(negedge clk);
    chk("t1 ld_gnt c1", 0, ld_gnt[0], 1);
    chk("t1 ld_stall c1", 0, ld_stall[0], 1);
    for (int c = 2; c <= 3; c++) begin
      tick;
      @(negedge clk);
      chk("t1 mem_en busy", 0, mem_en[0], 1);
      chk("t1 mem_rw_mode", 0, mem_rw_mode[0], 0);
      chk("t1 mem_addr", 0, mem_addr[0], 32'h100);
      chk("t1 ld_stall busy", 0, ld_stall[0], 1);
    end
    tick;
    @(negedge clk);
    chk("t1 ld_rsp_valid c4", 0, ld_rsp_valid[0], 1);
    chk("t1 ld_rsp_data c4", 0, ld_rsp_data[0], 32'hDEADBEEF);
    chk("t1 ld_stall c4", 0, ld_stall[0], 0);
    chk("t1 mem_en c4", 0, mem_en[0], 0);
    tick;
    ld_req[0] = 1'b0;
    st_req[0] = 1'b1;
    st_addr[0] = 32'h200;
    st_wdata[0] = 32'h12345678;
    st_wstrb[0] = 4'h3;
    @(negedge clk);
    chk("t2 st_gnt", 0, st_gnt[0], 1);
    chk("t2 ld_gnt", 0, ld_gnt[0], 0);
    for (int c = 0; c < 2; c++) begin
      tick;
      @(negedge clk);
      chk("t2 mem_rw_mode", 0, mem_rw_mode[0], 1);
      chk("t2 mem_addr", 0, mem_addr[0], 32'h200);
      chk("t2 mem_wdata", 0, mem_wdata[0], 32'h12345678);
      chk("t2 mem_wstrb", 0, mem_wstrb[0], 4'h3);
      chk("t2 ld_rsp_valid", 0, ld_rsp_valid[0], 0);
    end
    tick;
    @(negedge clk);
    chk("t2 st_done", 0, st_done[0], 1);
    chk("t2 ld_rsp_valid resp", 0, ld_rsp_valid[0], 0);
    chk("t2 ld_stall resp", 0, ld_stall[0], 0);
    tick;
    st_req[0] = 1'b0;
    tick;
    rst[0] = 1'b1;
    tick;
    rst[0] = 1'b0;
    ld_req[0] = 1'b1;
    st_req[0] = 1'b1;
    ld_addr[0] = 32'h140;
    st_addr[0] = 32'h240;
    st_wdata[0] = 32'hCAFE0001;
    st_wstrb[0] = 4'hF;
    @(negedge clk);
    chk("t3 ld_gnt c1", 0, ld_gnt[0], 1);
    chk("t3 st_gnt c1", 0, st_gnt[0], 0);
    tick;
    tick;
    tick;
    @(negedge clk);
    chk("t3 st_gnt c4", 0, st_gnt[0], 1);
    chk("t3 ld_rsp_valid c4", 0, ld_rsp_valid[0], 1);
    tick;
    ld_req[0] = 1'b0;
    tick;
    tick;
    @(negedge clk);
    chk("t3 st_done c7", 0, st_done[0], 1);
    tick;
    st_req[0] = 1'b0;
    tick;
    ld_req[0] = 1'b1;
    st_req[0] = 1'b1;
    last = -1;
    exp_st = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4 single grant", 0, !(ld_gnt[0] && st_gnt[0]), 1);
      if (ld_gnt[0] || st_gnt[0]) begin
        chk("t4 alternation", 0, st_gnt[0], exp_st);
        exp_st = !exp_st;
        if (last >= 0) chk("t4 grant spacing", 0, i - last, 3);
        last = i;
      end
      tick;
    end
    chk("t4 grant count", 0, exp_st, 1);
    drain(0);
    ld_req[0] = 1'b1;
    ld_addr[0] = 32'h300;
    @(negedge clk);
    chk("t5 ld_gnt", 0, ld_gnt[0], 1);
    tick;
    tick;
    rst[0] = 1'b1;
    ld_req[0] = 1'b0;
    tick;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("t5 mem_en after rst", 0, mem_en[0], 0);
    chk("t5 ld_rsp_valid after rst", 0, ld_rsp_valid[0], 0);
    chk("t5 ld_stall after rst", 0, ld_stall[0], 0);
    chk("t5 mem_addr after rst", 0, mem_addr[0], 32'h0);
    chk("t5 ld_rsp_data after rst", 0, ld_rsp_data[0], 32'h0);
    tick;
    ld_req[0] = 1'b1;
    ld_addr[0] = 32'h104;
    @(negedge clk);
    chk("t5 fresh ld_gnt", 0, ld_gnt[0], 1);
    tick;
    tick;
    tick;
    @(negedge clk);
    chk("t5 fresh ld_rsp_valid", 0, ld_rsp_valid[0], 1);
    chk("t5 fresh ld_rsp_data", 0, ld_rsp_data[0], 32'h0104FEFB);
    tick;
    ld_req[0] = 1'b0;
    tick;
    rand_run(0, 300);
    drain(0);
    rst[1] = 1'b0;
    ld_req[1] = 1'b1;
    st_req[1] = 1'b1;
    ld_addr[1] = 32'h500;
    st_addr[1] = 32'h600;
    st_wdata[1] = 32'hA5A5A5A5;
    st_wstrb[1] = 4'h9;
    ne = 0;
    gl = -100;
    gs = -100;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mem_en[1]) ne++;
      if (ld_gnt[1]) gl = i;
      if (st_gnt[1]) gs = i;
      if (ld_rsp_valid[1]) chk("t6 load latency", 1, i - gl, 2);
      if (st_done[1]) chk("t6 store latency", 1, i - gs, 2);
      tick;
    end
    chk("t6 mem_en duty", 1, ne, 8);
    drain(1);
    rand_run(1, 200);
    drain(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end
endmodule
